// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes,
// opcode constants, the illegal-format filler word, FSM states, the
// request bundle and small word builders used by the LI expansion.
package inst_enc_pkg;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_LI   = 3'd6;
  localparam logic [2:0] FMT_RSVD = 3'd7;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // output register empty
    S_OUT  = 2'd1,  // one word held
    S_LI2  = 2'd2   // first LI word held, ADDI word pending
  } state_t;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  // ADDI rd, rs1, imm12
  function automatic logic [31:0] addi_word(input logic [4:0] rd,
                                            input logic [4:0] rs1,
                                            input logic [11:0] imm12);
    return {imm12, rs1, 3'b000, rd, OP_OPIMM};
  endfunction

  // LUI rd, hi20
  function automatic logic [31:0] lui_word(input logic [4:0] rd,
                                           input logic [19:0] hi20);
    return {hi20, rd, OP_LUI};
  endfunction

endpackage

// File: rtl/inst_encoder_imm_packer.sv
// Immediate scatter and range check for the I/S/B/U/J formats.
// Produces only the immediate bits in their instruction positions (all other
// bit positions zero); the top ORs in the register/opcode fields.
module imm_packer
  import inst_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        range_err
);

  // A value fits an N-bit signed field when bits [31:N-1] are all equal.
  logic fits12, fits13, fits21;

  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  // Scatter immediate bits per format; encoding always uses the truncated
  // low bits even when the range check fails.
  always_comb begin
    imm_bits  = '0;
    range_err = 1'b0;
    case (fmt)
      FMT_I: begin
        imm_bits  = {imm[11:0], 20'b0};
        range_err = ~fits12;
      end
      FMT_S: begin
        imm_bits  = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        range_err = ~fits12;
      end
      FMT_B: begin
        imm_bits  = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        range_err = ~fits13 | imm[0];
      end
      FMT_U: begin
        imm_bits  = {imm[31:12], 12'b0};
        range_err = |imm[11:0];
      end
      FMT_J: begin
        imm_bits  = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        range_err = ~fits21 | imm[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder with valid/ready on both sides.
// One output register stage: accepted request appears on the next cycle and
// is held while the consumer stalls. Optional LI pseudo-instruction expansion
// (LUI+ADDI) is built when INST_ENCODER_PSEUDO_LI_EN is defined; otherwise
// fmt=6 is treated like the reserved format.
module inst_encoder #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_WORD = inst_enc_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic            out_err
);
  import inst_enc_pkg::*;

  enc_req_t    req;
  state_t      state, state_nx;
  logic [31:0] imm_bits;
  logic        imm_err;
  logic [31:0] reg_bits;
  logic [31:0] first_inst;
  logic        first_err;
  logic        accept;
  logic        load_first;

  assign req = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                 rs2: in_rs2, funct3: in_funct3, funct7: in_funct7,
                 imm: in_imm};

  imm_packer u_imm_packer (
    .fmt       (req.fmt),
    .imm       (req.imm),
    .imm_bits  (imm_bits),
    .range_err (imm_err)
  );

`ifdef INST_ENCODER_PSEUDO_LI_EN
  logic [31:0] li_sum;
  logic        li_small;
  logic        li_two;
  logic [31:0] second_inst;
  logic [31:0] pend_inst;
  logic        load_second;

  // hi is the rounded upper part so that LUI hi + sext(lo) == imm.
  assign li_sum   = req.imm + 32'h0000_0800;
  assign li_small = (&req.imm[31:11]) | ~(|req.imm[31:11]);
`endif

  // Build the first (or only) word for the incoming request.
  always_comb begin
    reg_bits   = '0;
    first_inst = NOP_WORD;
    first_err  = 1'b1;
`ifdef INST_ENCODER_PSEUDO_LI_EN
    li_two      = 1'b0;
    second_inst = '0;
`endif
    case (req.fmt)
      FMT_R:        reg_bits = {req.funct7, req.rs2, req.rs1, req.funct3,
                                req.rd, req.opcode};
      FMT_I:        reg_bits = {12'b0, req.rs1, req.funct3, req.rd, req.opcode};
      FMT_S, FMT_B: reg_bits = {7'b0, req.rs2, req.rs1, req.funct3, 5'b0,
                                req.opcode};
      FMT_U, FMT_J: reg_bits = {20'b0, req.rd, req.opcode};
      default:      reg_bits = '0;
    endcase
    if (req.fmt <= FMT_J) begin
      first_inst = reg_bits | imm_bits;
      first_err  = imm_err;
    end
`ifdef INST_ENCODER_PSEUDO_LI_EN
    if (req.fmt == FMT_LI) begin
      first_err   = 1'b0;
      second_inst = addi_word(req.rd, req.rd, req.imm[11:0]);
      if (li_small) begin
        first_inst = addi_word(req.rd, 5'd0, req.imm[11:0]);
      end else begin
        first_inst = lui_word(req.rd, li_sum[31:12]);
        li_two     = |req.imm[11:0];
      end
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state, handshake and output-register load enables.
  always_comb begin
    state_nx   = state;
    load_first = 1'b0;
`ifdef INST_ENCODER_PSEUDO_LI_EN
    load_second = 1'b0;
`endif
    in_ready = (state == S_IDLE) || (state == S_OUT && out_ready);
    accept   = in_valid && in_ready;
    case (state)
      S_IDLE, S_OUT: begin
        if (accept) begin
          load_first = 1'b1;
          state_nx   = S_OUT;
`ifdef INST_ENCODER_PSEUDO_LI_EN
          if (li_two) state_nx = S_LI2;
`endif
        end else if (state == S_OUT && out_ready) begin
          state_nx = S_IDLE;
        end
      end
`ifdef INST_ENCODER_PSEUDO_LI_EN
      S_LI2: begin
        if (out_ready) begin
          load_second = 1'b1;
          state_nx    = S_OUT;
        end
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Output register: holds the presented word until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_inst <= '0;
      out_err  <= 1'b0;
    end else if (load_first) begin
      out_inst <= first_inst;
      out_err  <= first_err;
`ifdef INST_ENCODER_PSEUDO_LI_EN
    end else if (load_second) begin
      out_inst <= pend_inst;
      out_err  <= 1'b0;
`endif
    end
  end

`ifdef INST_ENCODER_PSEUDO_LI_EN
  // Pending ADDI half of a two-word LI, captured with the LUI word.
  always_ff @(posedge clk) begin
    if (rst)             pend_inst <= '0;
    else if (load_first) pend_inst <= second_inst;
  end
`endif

  assign out_valid = (state != S_IDLE);

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RV32I instruction encoder: takes decoded fields (format, opcode, rd, rs1, rs2, funct3, funct7, full 32-bit immediate) and packs them into a 32-bit instruction word.
- It is the inverse of the core's immediate/field decode path. It scatters immediate bits into the I/S/B/U/J positions and range-checks them.
- It expands the LI pseudo-instruction into LUI+ADDI.
- It feeds the boot-image builder and the self-test stimulus path with a valid/ready handshake on both sides.

Parameters:
XLEN, 32, data/instruction width; only 32 supported.
NOP_WORD, 32'h00000013, word emitted on illegal format.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept request this cycle
in_fmt  input  3  0=R,1=I,2=S,3=B,4=U,5=J,6=LI,7=reserved
in_opcode  input  7  opcode field (ignored for LI)
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3 field
in_funct7  input  7  funct7 field (R only)
in_imm  input  32  full-value immediate (byte offset for B/J; full value for U)
out_valid  output  1  out_inst valid
out_ready  input  1  consumer accepts word
out_inst  output  32  encoded instruction
out_err  output  1  immediate out of range/misaligned, or illegal format; qualified by out_valid

Behaviour:
- Transfers occur on cycles where valid&&ready are both high.
- Reset: out_valid=0, out_inst=0, out_err=0, state=S_IDLE. in_ready=1 in the cycle after reset deasserts.
- Latency: accepted request produces out_valid on the next cycle.
- Output register holds out_inst/out_err stable while out_valid && !out_ready.
- States:
  - S_IDLE: output register empty.
  - S_OUT: word held.
  - S_LI2: first LI word held, second pending.
- in_ready = (state==S_IDLE) || (state==S_OUT && out_ready). This gives full throughput, one word per cycle, with no bubble on back-to-back requests.
- Transitions:
  - S_IDLE/S_OUT accept non-LI or single-word LI -> S_OUT.
  - S_OUT with out_ready && !in_valid -> S_IDLE.
  - Accept two-word LI -> S_LI2.
  - S_LI2 && out_ready -> load ADDI word, go to S_OUT. in_ready=0 throughout S_LI2.
- Range rules (signed in_imm); violation sets out_err=1. The word is still encoded from the truncated low bits.
  - I, S: -2048..2047.
  - B: -4096..4094 and bit0==0.
  - J: -1048576..1048574 and bit0==0.
  - U: in_imm[11:0]==0. Encoded field is in_imm[31:12].
  - R: in_imm ignored, never errors.
- LI expansion, rd=in_rd:
  - If imm in -2048..2047: single ADDI rd,x0,imm.
  - Else hi=(imm+32'h800)>>12 (modulo 2^32), lo=imm[11:0] sign-extended. Emit LUI rd,hi, then ADDI rd,rd,lo.
  - If lo==0, emit LUI only.
  - LI never sets out_err.
- fmt=7: emit NOP_WORD with out_err=1.
- Reset mid-operation (any state, including S_LI2) drops held and pending words.

Optional Feature:
INST_ENCODER_PSEUDO_LI_EN
- Defined: fmt=6 performs LI expansion as above; S_LI2 exists.
- Undefined: fmt=6 is treated as reserved (NOP_WORD, out_err=1); S_LI2 and the hi/lo adder are not built.

Decomposition:
- Package inst_enc_pkg holds:
  - format codes FMT_R..FMT_LI, FMT_RSVD
  - opcode constants OP_LUI=7'b0110111, OP_OPIMM=7'b0010011
  - NOP_WORD
  - state enum
- One combinational sub-module imm_packer(fmt, imm) -> {scattered 32-bit field mask contribution, range_err}. The top holds the FSM, the LI split and the output register.

Test Plan:
- fmt=I, opcode=0010011, rd=5, rs1=0, funct3=0, imm=5, out_ready=1 -> next cycle out_inst=32'h00500293, out_err=0.
- fmt=B, opcode=1100011, rs1=1, rs2=2, funct3=0, imm=8 -> 32'h00208463. Then same with imm=7 -> out_err=1.
- LI rd=10, imm=32'h12345678 -> 32'h12345537 then 32'h67850513. in_ready=0 during the second word.
- LI rd=10, imm=4095 -> 32'h00001537 then 32'hFFF50513. LI rd=10, imm=32'h00001000 -> single word 32'h00001537.
- LI 32'h12345678 with out_ready held low 3 cycles -> out_inst stable at 32'h12345537, in_ready=0. Assert rst while in S_LI2 -> out_valid=0 next cycle, second word never emitted.
- Back-to-back 4 I-type requests with out_ready=1 -> 4 words on 4 consecutive cycles. fmt=7 -> 32'h00000013 with out_err=1.
